scoreboard_regfile: RTL
=======================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The module SHALL have parameter NREGS, default 32, register count, power of two from 8 to 64.
REQ-003 The module SHALL have parameter NRD, default 2, read port count, 1 to 4.
REQ-004 The module SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and is never written or marked busy.
REQ-005 The module SHALL have localparam AW = $clog2(NREGS).
REQ-006 The module SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 The module SHALL have port reset_n, input, 1 bit, reset, synchronous, active-low.
REQ-008 The module SHALL have port rd_addr, input, NRD*AW bits, read addresses; port i uses slice [i*AW +: AW].
REQ-009 The module SHALL have port rd_data, output, NRD*XLEN bits, read data; port i uses slice [i*XLEN +: XLEN].
REQ-010 The module SHALL have port rd_busy, output, NRD bits, pending-producer flag per read port.
REQ-011 The module SHALL have port wr_en, input, 2 bits, write enable for each of write ports 0 and 1.
REQ-012 The module SHALL have port wr_addr, input, 2*AW bits, write addresses.
REQ-013 The module SHALL have port wr_data, input, 2*XLEN bits, write data.
REQ-014 The module SHALL have port issue_en, input, 1 bit, marks issue_addr busy.
REQ-015 The module SHALL have port issue_addr, input, AW bits, destination register of the issuing instruction.
REQ-016 The module SHALL have port flush, input, 1 bit, clears all busy bits.
REQ-017 The module SHALL have port busy_vec, output, NREGS bits, registered busy bits.
REQ-018 The module SHALL have port conflict, output, 1 bit, registered same-address double-write flag.

Function
REQ-019 Reads SHALL be combinational, with zero cycles of latency from rd_addr to rd_data.
REQ-020 Each read port SHALL resolve in this priority order: ZERO_REG and address 0 give 0; else a matching wr_en[1] write gives wr_data port 1; else a matching wr_en[0] write gives wr_data port 0; else the stored array value.
REQ-021 Enabled writes on both ports SHALL commit at the same clk edge.
REQ-022 When both writes target the same address, port 1 SHALL win, and conflict SHALL be 1 for exactly the following cycle.
REQ-023 Writes to register 0 SHALL be discarded when ZERO_REG=1, and the bypass in REQ-020 SHALL not apply to them.
REQ-024 Busy update for each register at the clk edge SHALL follow this priority: flush clears; else issue_en matching the address sets; else an enabled write to the address clears; else the bit holds.
REQ-025 Issue and writeback to the same address in the same cycle SHALL leave busy=1, since the new producer wins.
REQ-026 issue_en with issue_addr=0 SHALL be ignored when ZERO_REG=1.
REQ-027 rd_busy[i] SHALL equal busy[rd_addr_i] AND NOT (an enabled write to rd_addr_i this cycle), so that it agrees with the bypassed data.
REQ-028 rd_busy[i] SHALL be 0 for address 0 when ZERO_REG=1.
REQ-029 busy_vec SHALL reflect register state only, with no same-cycle bypass.
REQ-030 flush asserted together with writes SHALL still commit the write data, and all busy bits SHALL be 0 afterwards.

Reset
REQ-031 When reset_n=0 at a clk edge, all registers SHALL become 0, busy_vec SHALL become 0, and conflict SHALL become 0.
REQ-032 reset SHALL take priority over writes, issue and flush in the same cycle.
REQ-033 During reset, combinational read bypass of a concurrent write SHALL still apply, but the write SHALL not be stored.
REQ-034 Reset asserted while busy bits are set SHALL clear them in one cycle, with no drain.

Verification
REQ-035 The bench SHALL cover: reset, then read all addresses -> every rd_data=0, busy_vec=0, conflict=0.
REQ-036 The bench SHALL cover: wr_en=2'b01, addr 5, data 0xDEADBEEF, with rd_addr port0=5 the same cycle -> rd_data=0xDEADBEEF combinationally; next cycle with wr_en=0 -> still 0xDEADBEEF.
REQ-037 The bench SHALL cover: both ports write addr 7, port0 0x11 and port1 0x22 -> same-cycle read 0x22, stored 0x22, conflict=1 for one cycle only.
REQ-038 The bench SHALL cover: issue addr 3, then next cycle read 3 -> rd_busy=1; write addr 3 with 0x55 -> same-cycle rd_busy=0 and rd_data=0x55, busy_vec[3]=0 next cycle.
REQ-039 The bench SHALL cover: issue addr 4 plus port0 write addr 4 in one cycle -> busy_vec[4]=1 after the edge; then flush plus issue addr 9 -> busy_vec all 0.
REQ-040 The bench SHALL cover: ZERO_REG=1, write 0xFFFFFFFF to addr 0 and issue addr 0 -> read 0 is 0 the same and next cycle, busy_vec[0]=0.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// Two-write-port register file with combinational bypassed reads and a
// per-register busy scoreboard that tracks in-flight producers.
module scoreboard_regfile #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [1:0]            wr_en,
  input  logic [2*AW-1:0]       wr_addr,
  input  logic [2*XLEN-1:0]     wr_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec,
  output logic                  conflict
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]          regs_q [NREGS];
  logic [NREGS-1:0]         busy_q, busy_d;
  logic                     conflict_q;

  logic [1:0][AW-1:0]       waddr;
  logic [1:0][XLEN-1:0]     wdata;
  logic [1:0]               wvalid;
  logic                     issue_valid;
  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;

  assign waddr = wr_addr;
  assign wdata = wr_data;
  assign raddr = rd_addr;

  // Writes and issues aimed at the hardwired zero register vanish here, so
  // neither the bypass nor the busy logic ever sees them.
  assign wvalid[0]   = wr_en[0] && !(ZR && waddr[0] == '0);
  assign wvalid[1]   = wr_en[1] && !(ZR && waddr[1] == '0);
  assign issue_valid = issue_en && !(ZR && issue_addr == '0);

  always_comb begin
    rdata   = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ZR && raddr[i] == '0) begin
        rdata[i] = '0;
      end else if (wvalid[1] && waddr[1] == raddr[i]) begin
        rdata[i] = wdata[1];
      end else if (wvalid[0] && waddr[0] == raddr[i]) begin
        rdata[i] = wdata[0];
      end else begin
        rdata[i] = regs_q[raddr[i]];
      end
      rd_busy[i] = busy_q[raddr[i]]
                   && !(wvalid[0] && waddr[0] == raddr[i])
                   && !(wvalid[1] && waddr[1] == raddr[i])
                   && !(ZR && raddr[i] == '0);
    end
  end

  assign rd_data = rdata;

  // A new issue beats a writeback to the same register: the newer producer owns it.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (issue_valid && issue_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if ((wvalid[0] && waddr[0] == AW'(r)) ||
                   (wvalid[1] && waddr[1] == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (wvalid[0]) regs_q[waddr[0]] <= wdata[0];
      if (wvalid[1]) regs_q[waddr[1]] <= wdata[1];
      busy_q     <= busy_d;
      conflict_q <= (&wvalid) && (waddr[0] == waddr[1]);
    end
  end

  assign busy_vec = busy_q;
  assign conflict = conflict_q;

endmodule
